// File: rtl/sensor_pwr_seq_pkg.sv
// Shared state encoding and default timing constants for the sensor power sequencer.
package sensor_pwr_seq_pkg;

  typedef enum logic [2:0] {
    ST_OFF   = 3'd0,
    ST_SETUP = 3'd1,
    ST_PWRUP = 3'd2,
    ST_ON    = 3'd3,
    ST_PWRDN = 3'd4
  } pwr_state_t;

  localparam int DEF_N_SENS  = 2;
  localparam int DEF_T_SETUP = 1000;
  localparam int DEF_T_BOOT  = 2000000;
  localparam int DEF_T_OFF   = 1000;
  localparam int DEF_XVS_TMO = 10000000;
  localparam int DEF_FRM_W   = 32;
  localparam int LED_DIV_W   = 23;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sensor_pwr_chan.sv
// One sensor channel: power FSM with shared sequence timer, input synchronisers,
// frame counter, XVS watchdog and status LED. All outputs registered.
module sensor_pwr_chan
  import sensor_pwr_seq_pkg::*;
#(
  parameter int T_SETUP = DEF_T_SETUP,
  parameter int T_BOOT  = DEF_T_BOOT,
  parameter int T_OFF   = DEF_T_OFF,
  parameter int XVS_TMO = DEF_XVS_TMO,
  parameter int FRM_W   = DEF_FRM_W,
  parameter int TMR_W   = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_sla_sel,
  input  logic             i_clr,
  input  logic             i_xvs,
  input  logic             i_strobe,
  output logic             o_pwdn,
  output logic             o_sla_sel,
  output logic             o_ready,
  output logic             o_strobe_sync,
  output logic             o_xvs_lost,
  output logic [FRM_W-1:0] o_frame_cnt,
  output logic             o_led
);

  localparam logic [TMR_W-1:0] L_SETUP_LAST = TMR_W'(T_SETUP - 1);
  localparam logic [TMR_W-1:0] L_BOOT_LAST  = TMR_W'(T_BOOT - 1);
  localparam logic [TMR_W-1:0] L_OFF_LAST   = TMR_W'(T_OFF - 1);
  localparam logic [TMR_W-1:0] L_TMO        = TMR_W'(XVS_TMO);
  localparam logic [TMR_W-1:0] L_TMO_LAST   = TMR_W'(XVS_TMO - 1);

  pwr_state_t            r_state;
  pwr_state_t            w_state_nxt;
  logic [TMR_W-1:0]      r_tmr, w_tmr_nxt;
  logic [TMR_W-1:0]      r_wd, w_wd_nxt;
  logic [FRM_W-1:0]      r_frame, w_frame_nxt;
  logic                  r_lost, w_lost_nxt;
  logic                  r_xvs_meta, r_xvs_sync, r_xvs_prev;
  logic                  r_stb_meta, r_stb_sync;
  logic [LED_DIV_W-1:0]  r_led_div;
  logic                  r_blink;
  logic                  r_pwdn, r_sla, r_ready, r_strobe_sync, r_led;
  logic                  w_xvs_edge;
  logic                  w_led_nxt;

  assign w_xvs_edge = r_xvs_sync & ~r_xvs_prev;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_OFF;
      r_tmr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_tmr   <= w_tmr_nxt;
    end
  end

  // A dropped enable outranks an expiring timer; PWRDN always runs its full hold.
  always_comb begin
    w_state_nxt = r_state;
    w_tmr_nxt   = r_tmr + 1'b1;
    case (r_state)
      ST_OFF: begin
        w_tmr_nxt = '0;
        if (i_en) w_state_nxt = ST_SETUP;
      end
      ST_SETUP: begin
        if (!i_en) begin
          w_state_nxt = ST_PWRDN;
          w_tmr_nxt   = '0;
        end else if (r_tmr == L_SETUP_LAST) begin
          w_state_nxt = ST_PWRUP;
          w_tmr_nxt   = '0;
        end
      end
      ST_PWRUP: begin
        if (!i_en) begin
          w_state_nxt = ST_PWRDN;
          w_tmr_nxt   = '0;
        end else if (r_tmr == L_BOOT_LAST) begin
          w_state_nxt = ST_ON;
          w_tmr_nxt   = '0;
        end
      end
      ST_ON: begin
        w_tmr_nxt = '0;
        if (!i_en) w_state_nxt = ST_PWRDN;
      end
      ST_PWRDN: begin
        if (r_tmr == L_OFF_LAST) begin
          w_state_nxt = ST_OFF;
          w_tmr_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = ST_OFF;
        w_tmr_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    w_frame_nxt = r_frame;
    w_wd_nxt    = r_wd;
    w_lost_nxt  = r_lost;
    if (i_clr) begin
      w_frame_nxt = '0;
      w_wd_nxt    = '0;
      w_lost_nxt  = 1'b0;
    end else if (r_state != ST_ON) begin
      w_wd_nxt = '0;
    end else if (w_xvs_edge) begin
      w_frame_nxt = r_frame + 1'b1;
      w_wd_nxt    = '0;
    end else if (r_wd != L_TMO) begin
      w_wd_nxt = r_wd + 1'b1;
      if (r_wd == L_TMO_LAST) w_lost_nxt = 1'b1;
    end
  end

  always_comb begin
    w_led_nxt = 1'b0;
    if (w_state_nxt == ST_ON)
      w_led_nxt = ~w_lost_nxt;
    else if (w_state_nxt == ST_SETUP || w_state_nxt == ST_PWRUP)
      w_led_nxt = ~r_blink;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_xvs_meta    <= 1'b0;
      r_xvs_sync    <= 1'b0;
      r_xvs_prev    <= 1'b0;
      r_stb_meta    <= 1'b0;
      r_stb_sync    <= 1'b0;
      r_frame       <= '0;
      r_wd          <= '0;
      r_lost        <= 1'b0;
      r_led_div     <= '0;
      r_blink       <= 1'b0;
      r_pwdn        <= 1'b0;
      r_sla         <= 1'b0;
      r_ready       <= 1'b0;
      r_strobe_sync <= 1'b0;
      r_led         <= 1'b0;
    end else begin
      r_xvs_meta    <= i_xvs;
      r_xvs_sync    <= r_xvs_meta;
      r_xvs_prev    <= r_xvs_sync;
      r_stb_meta    <= i_strobe;
      r_stb_sync    <= r_stb_meta;
      r_frame       <= w_frame_nxt;
      r_wd          <= w_wd_nxt;
      r_lost        <= w_lost_nxt;
      r_pwdn        <= (w_state_nxt == ST_PWRUP) || (w_state_nxt == ST_ON);
      r_ready       <= (w_state_nxt == ST_ON);
      r_strobe_sync <= r_stb_sync && (w_state_nxt == ST_ON);
      r_led         <= w_led_nxt;
      if (r_state == ST_OFF && w_state_nxt == ST_SETUP) r_sla <= i_sla_sel;
      if (r_state == ST_SETUP || r_state == ST_PWRUP) begin
        r_led_div <= r_led_div + 1'b1;
        if (&r_led_div) r_blink <= ~r_blink;
      end else begin
        r_led_div <= '0;
        r_blink   <= 1'b0;
      end
    end
  end

  assign o_pwdn        = r_pwdn;
  assign o_sla_sel     = r_sla;
  assign o_ready       = r_ready;
  assign o_strobe_sync = r_strobe_sync;
  assign o_xvs_lost    = r_lost;
  assign o_frame_cnt   = r_frame;
  assign o_led         = r_led;

endmodule

// File: rtl/sensor_pwr_seq.sv
// Multi-channel camera sensor power sequencer: N_SENS independent channels
// sharing only clock, reset and the counter/flag clear.
module sensor_pwr_seq
  import sensor_pwr_seq_pkg::*;
#(
  parameter int N_SENS  = DEF_N_SENS,
  parameter int T_SETUP = DEF_T_SETUP,
  parameter int T_BOOT  = DEF_T_BOOT,
  parameter int T_OFF   = DEF_T_OFF,
  parameter int XVS_TMO = DEF_XVS_TMO,
  parameter int FRM_W   = DEF_FRM_W
) (
  input  logic                    Clk100,
  input  logic                    Rst,
  input  logic [N_SENS-1:0]       Cfg_En,
  input  logic [N_SENS-1:0]       Cfg_SlaSel,
  input  logic                    Clr,
  input  logic [N_SENS-1:0]       Sensor_Xvs,
  input  logic [N_SENS-1:0]       Sensor_Strobe,
  output logic [N_SENS-1:0]       Sensor_Pwdn,
  output logic [N_SENS-1:0]       Sensor_SlaSel,
  output logic [N_SENS-1:0]       Ready,
  output logic [N_SENS-1:0]       Strobe_Sync,
  output logic [N_SENS-1:0]       Xvs_Lost,
  output logic [N_SENS*FRM_W-1:0] Frame_Cnt,
  output logic [N_SENS-1:0]       Led
);

  localparam int TMR_W = $clog2(max2(max2(T_SETUP, T_BOOT), max2(T_OFF, XVS_TMO)) + 1);

  for (genvar g = 0; g < N_SENS; g++) begin : g_chan
    sensor_pwr_chan #(
      .T_SETUP (T_SETUP),
      .T_BOOT  (T_BOOT),
      .T_OFF   (T_OFF),
      .XVS_TMO (XVS_TMO),
      .FRM_W   (FRM_W),
      .TMR_W   (TMR_W)
    ) u_chan (
      .i_clk         (Clk100),
      .i_rst         (Rst),
      .i_en          (Cfg_En[g]),
      .i_sla_sel     (Cfg_SlaSel[g]),
      .i_clr         (Clr),
      .i_xvs         (Sensor_Xvs[g]),
      .i_strobe      (Sensor_Strobe[g]),
      .o_pwdn        (Sensor_Pwdn[g]),
      .o_sla_sel     (Sensor_SlaSel[g]),
      .o_ready       (Ready[g]),
      .o_strobe_sync (Strobe_Sync[g]),
      .o_xvs_lost    (Xvs_Lost[g]),
      .o_frame_cnt   (Frame_Cnt[g*FRM_W +: FRM_W]),
      .o_led         (Led[g])
    );
  end

endmodule

// File: tb/tb_sensor_pwr_seq.sv
// Directed bench for sensor_pwr_seq with short timing parameters; edge numbers
// in comments count from the first edge that samples Cfg_En[0]=1.
module tb_sensor_pwr_seq;

  localparam int N_SENS = 2;
  localparam int FRM_W  = 4;

  logic                    Clk100 = 1'b0;
  logic                    Rst;
  logic [N_SENS-1:0]       Cfg_En, Cfg_SlaSel, Sensor_Xvs, Sensor_Strobe;
  logic                    Clr;
  logic [N_SENS-1:0]       Sensor_Pwdn, Sensor_SlaSel, Ready, Strobe_Sync, Xvs_Lost, Led;
  logic [N_SENS*FRM_W-1:0] Frame_Cnt;

  int n_tests = 0;
  int n_fail  = 0;

  sensor_pwr_seq #(
    .N_SENS(N_SENS), .T_SETUP(4), .T_BOOT(8), .T_OFF(3), .XVS_TMO(20), .FRM_W(FRM_W)
  ) dut (
    .Clk100(Clk100), .Rst(Rst), .Cfg_En(Cfg_En), .Cfg_SlaSel(Cfg_SlaSel), .Clr(Clr),
    .Sensor_Xvs(Sensor_Xvs), .Sensor_Strobe(Sensor_Strobe),
    .Sensor_Pwdn(Sensor_Pwdn), .Sensor_SlaSel(Sensor_SlaSel), .Ready(Ready),
    .Strobe_Sync(Strobe_Sync), .Xvs_Lost(Xvs_Lost), .Frame_Cnt(Frame_Cnt), .Led(Led)
  );

  always #5 Clk100 = ~Clk100;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clk100);
      #1;
    end
  endtask

  initial begin
    Rst = 1'b1; Cfg_En = '0; Cfg_SlaSel = '0; Clr = 1'b0;
    Sensor_Xvs = '0; Sensor_Strobe = '0;
    tick(2);
    check_eq("rst_pwdn",   Sensor_Pwdn,   0);
    check_eq("rst_ready",  Ready,         0);
    check_eq("rst_sla",    Sensor_SlaSel, 0);
    check_eq("rst_led",    Led,           0);
    check_eq("rst_lost",   Xvs_Lost,      0);
    check_eq("rst_frame",  Frame_Cnt,     0);
    check_eq("rst_strobe", Strobe_Sync,   0);
    Rst = 1'b0;
    tick(1);

    // Power-up sequence on channel 0
    Cfg_En = 2'b01; Cfg_SlaSel = 2'b01;
    tick(1);                                    // edge 0
    check_eq("sla_e0",    Sensor_SlaSel, 2'b01);
    check_eq("pwdn_e0",   Sensor_Pwdn,   2'b00);
    check_eq("led_setup", Led,           2'b01);
    Cfg_SlaSel = 2'b00;
    tick(3);                                    // edge 3
    check_eq("pwdn_e3",   Sensor_Pwdn,   2'b00);
    tick(1);                                    // edge 4
    check_eq("pwdn_e4",   Sensor_Pwdn,   2'b01);
    check_eq("ready_e4",  Ready,         2'b00);
    tick(7);                                    // edge 11
    check_eq("ready_e11", Ready,         2'b00);
    tick(1);                                    // edge 12
    check_eq("ready_e12", Ready,         2'b01);
    check_eq("led_on",    Led,           2'b01);
    check_eq("sla_hold",  Sensor_SlaSel, 2'b01);
    check_eq("ch1_off",   Sensor_Pwdn,   2'b01);

    Sensor_Strobe = 2'b11;
    tick(3);                                    // edge 15
    check_eq("strobe_sync", Strobe_Sync, 2'b01);
    Sensor_Strobe = 2'b00;

    // 17 XVS pulses every 10 cycles; each counts 3 edges after it is raised
    for (int i = 0; i < 17; i++) begin
      Sensor_Xvs = 2'b01;
      tick(1);
      Sensor_Xvs = 2'b00;
      tick(9);
      if (i == 14) check_eq("frame_15",   Frame_Cnt[3:0], 15);
      if (i == 15) check_eq("frame_wrap", Frame_Cnt[3:0], 0);
    end                                         // edge 185, last XVS counted at 178
    check_eq("frame_end", Frame_Cnt[3:0], 1);
    check_eq("lost_ok",   Xvs_Lost,       2'b00);
    check_eq("ch1_frame", Frame_Cnt[7:4], 0);

    tick(12);                                   // edge 197: watchdog at 19
    check_eq("lost_pre", Xvs_Lost, 2'b00);
    tick(1);                                    // edge 198: watchdog reaches 20
    check_eq("lost_set",   Xvs_Lost, 2'b01);
    check_eq("led_lost",   Led,      2'b00);
    check_eq("ready_lost", Ready,    2'b01);

    Clr = 1'b1;
    tick(1);                                    // edge 199
    Clr = 1'b0;
    check_eq("lost_clr",  Xvs_Lost,       2'b00);
    check_eq("frame_clr", Frame_Cnt[3:0], 0);
    check_eq("led_clr",   Led,            2'b01);

    Sensor_Xvs = 2'b01;
    tick(1);
    Sensor_Xvs = 2'b00;
    tick(2);                                    // edge 202
    check_eq("frame_one", Frame_Cnt[3:0], 1);
    Sensor_Xvs = 2'b01;
    tick(1);
    Sensor_Xvs = 2'b00;
    tick(1);
    Clr = 1'b1;
    tick(1);                                    // edge 205: XVS edge and Clr together
    Clr = 1'b0;
    check_eq("frame_clr_win", Frame_Cnt[3:0], 0);

    // Drop from ON, immediate re-request: T_OFF hold, OFF, then SETUP at 210
    Cfg_En = 2'b00;
    tick(1);                                    // edge 206
    check_eq("pwdn_off",  Sensor_Pwdn, 2'b00);
    check_eq("ready_off", Ready,       2'b00);
    check_eq("led_pwrdn", Led,         2'b00);
    Cfg_En = 2'b01;
    tick(7);                                    // edge 213
    check_eq("pwdn_213", Sensor_Pwdn, 2'b00);
    tick(1);                                    // edge 214 = P, in PWRUP
    check_eq("pwdn_214",    Sensor_Pwdn,   2'b01);
    check_eq("sla_relatch", Sensor_SlaSel, 2'b00);

    // Drop in PWRUP, re-rise one cycle later
    Cfg_SlaSel = 2'b01;
    Cfg_En = 2'b00;
    tick(1);                                    // P+1
    Cfg_En = 2'b01;
    check_eq("pwdn_drop", Sensor_Pwdn, 2'b00);
    for (int i = 0; i < 7; i++) begin
      tick(1);                                  // P+2 .. P+8
      check_eq("pwdn_hold", Sensor_Pwdn, 2'b00);
    end
    tick(1);                                    // P+9
    check_eq("pwdn_again",  Sensor_Pwdn, 2'b01);
    check_eq("ready_early", Ready,       2'b00);
    tick(7);                                    // P+16
    check_eq("ready_p16", Ready, 2'b00);
    tick(1);                                    // P+17 = Q
    check_eq("ready_p17",  Ready,         2'b01);
    check_eq("sla_second", Sensor_SlaSel, 2'b01);

    // Channel 1 up to PWRUP while channel 0 counts a frame, then async reset
    Cfg_En = 2'b11; Cfg_SlaSel = 2'b11;
    Sensor_Xvs = 2'b01; Sensor_Strobe = 2'b01;
    tick(1);                                    // Q+1
    Sensor_Xvs = 2'b00;
    tick(5);                                    // Q+6
    check_eq("pwdn_both",   Sensor_Pwdn,    2'b11);
    check_eq("frame_q",     Frame_Cnt[3:0], 1);
    check_eq("ch1_frame_q", Frame_Cnt[7:4], 0);
    check_eq("strobe_q",    Strobe_Sync,    2'b01);
    check_eq("sla_both",    Sensor_SlaSel,  2'b11);
    #3;
    Rst = 1'b1;
    #1;
    check_eq("arst_pwdn",   Sensor_Pwdn,   0);
    check_eq("arst_ready",  Ready,         0);
    check_eq("arst_sla",    Sensor_SlaSel, 0);
    check_eq("arst_led",    Led,           0);
    check_eq("arst_frame",  Frame_Cnt,     0);
    check_eq("arst_strobe", Strobe_Sync,   0);
    check_eq("arst_lost",   Xvs_Lost,      0);
    Sensor_Strobe = 2'b00;
    tick(1);                                    // edge R, still in reset
    Rst = 1'b0;
    tick(1);                                    // R+1: both enter SETUP
    check_eq("rel_sla",  Sensor_SlaSel, 2'b11);
    check_eq("rel_pwdn", Sensor_Pwdn,   2'b00);
    tick(3);                                    // R+4
    check_eq("rel_pwdn_r4", Sensor_Pwdn, 2'b00);
    tick(1);                                    // R+5
    check_eq("rel_pwdn_r5", Sensor_Pwdn, 2'b11);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sensor_pwr_seq.md
SENSOR_PWR_SEQ -- requirements
Module: sensor_pwr_seq

Interface
REQ-001 SHALL have parameter N_SENS, default 2: number of independent camera sensor channels (1..8).
REQ-002 SHALL have parameter T_SETUP, default 1000: Clk100 cycles SlaSel is held stable before power-up (>=1).
REQ-003 SHALL have parameter T_BOOT, default 2000000: Clk100 cycles after power-up before Ready (>=1).
REQ-004 SHALL have parameter T_OFF, default 1000: minimum power-down hold in Clk100 cycles (>=1).
REQ-005 SHALL have parameter XVS_TMO, default 10000000: Clk100 cycles without an XVS edge before loss is flagged (>=2).
REQ-006 SHALL have parameter FRM_W, default 32: frame counter width.
REQ-007 SHALL have ports: Clk100 in 1 system clock; Rst in 1 asynchronous active-high reset; one clock, no other clock domains.
REQ-008 SHALL have ports: Cfg_En in N_SENS per-sensor power request (Clk100 domain); Cfg_SlaSel in N_SENS requested I2C address select; Clr in 1 synchronous clear of counters and sticky flags.
REQ-009 SHALL have ports: Sensor_Xvs in N_SENS async vsync; Sensor_Strobe in N_SENS async strobe.
REQ-010 SHALL have ports: Sensor_Pwdn out N_SENS (0 = sensor held powered down); Sensor_SlaSel out N_SENS; Ready out N_SENS; Strobe_Sync out N_SENS; Xvs_Lost out N_SENS; Frame_Cnt out N_SENS*FRM_W, channel i at bits [i*FRM_W +: FRM_W]; Led out N_SENS.

Function
REQ-011 SHALL run one independent per-channel FSM with states OFF, SETUP, PWRUP, ON, PWRDN; all outputs registered.
REQ-012 OFF: Pwdn=0, Ready=0; Cfg_En=1 sampled at edge k -> SETUP at k, Sensor_SlaSel latches Cfg_SlaSel at k.
REQ-013 SETUP: Pwdn=0; after T_SETUP cycles -> PWRUP, Sensor_Pwdn=1 from edge k+T_SETUP.
REQ-014 PWRUP: Pwdn=1; after T_BOOT cycles -> ON, Ready=1 from edge k+T_SETUP+T_BOOT.
REQ-015 ON: Pwdn=1, Ready=1; stays while Cfg_En=1.
REQ-016 Cfg_En=0 in SETUP, PWRUP or ON -> PWRDN next edge: Pwdn=0, Ready=0 immediately.
REQ-017 PWRDN: ignores Cfg_En for T_OFF cycles, then -> OFF; if Cfg_En=1 on exit, next edge -> SETUP (no power glitch shorter than T_OFF).
REQ-018 Sensor_SlaSel SHALL change only on OFF->SETUP; Cfg_SlaSel changes in other states are ignored.
REQ-019 Sensor_Xvs and Sensor_Strobe SHALL pass through 2-flop synchronisers; Strobe_Sync = synced strobe AND Ready.
REQ-020 In ON, each synced XVS rising edge SHALL increment Frame_Cnt by 1, wrapping 2^FRM_W-1 -> 0; edges outside ON are not counted.
REQ-021 In ON, a watchdog counts cycles since last XVS edge (reset to 0 on edge and on entry to ON); reaching XVS_TMO sets Xvs_Lost (sticky), counter saturates.
REQ-022 Clr=1 SHALL zero all Frame_Cnt and Xvs_Lost and watchdogs next edge; Clr wins over a simultaneous XVS edge or timeout.
REQ-023 Led SHALL be 1 in ON, toggle every 2^23 cycles in SETUP/PWRUP, 0 otherwise; Xvs_Lost=1 in ON forces Led=0.
REQ-024 Channels SHALL not interact; simultaneous events on different channels are handled independently.

Reset
REQ-025 Rst=1 SHALL asynchronously force all channels to OFF: Pwdn=0, SlaSel=0, Ready=0, Strobe_Sync=0, Xvs_Lost=0, Frame_Cnt=0, Led=0, timers and synchronisers 0.
REQ-026 Rst mid-sequence (any state) SHALL drop Pwdn immediately; after release a channel with Cfg_En=1 restarts at SETUP, no T_OFF wait.

Structure
REQ-027 Shared package sensor_pwr_seq_pkg SHALL hold the state enum and default timing constants.
REQ-028 One sub-module sensor_pwr_chan (FSM, timer, sync, frame counter, watchdog) SHALL be instantiated N_SENS times by generate; timer width = clog2 of max(T_SETUP,T_BOOT,T_OFF,XVS_TMO)+1.

Verification (N_SENS=2, T_SETUP=4, T_BOOT=8, T_OFF=3, XVS_TMO=20, FRM_W=4)
REQ-029 Cfg_En[0]=1 at edge 0, SlaSel=1 -> SlaSel[0]=1 at edge 0, Pwdn[0]=1 at edge 4, Ready[0]=1 at edge 12; channel 1 stays OFF.
REQ-030 Ch0 ON, 17 XVS pulses every 10 cycles -> Frame_Cnt[0] wraps 15->0, ends at 1; Xvs_Lost[0]=0.
REQ-031 Ch0 ON, no XVS for 20 cycles -> Xvs_Lost[0]=1, Led[0]=0; Clr pulse -> Xvs_Lost[0]=0 next edge; Clr coincident with XVS edge -> Frame_Cnt[0]=0.
REQ-032 Cfg_En[0] drops in PWRUP, re-rises 1 cycle later -> Pwdn[0]=0 for >=3 cycles, then SETUP, Ready after 4+8 more cycles.
REQ-033 Rst asserted mid-PWRUP with Cfg_En=1 -> all outputs 0 asynchronously; after release Pwdn=1 after 4 cycles.
